// File: rtl/flag_sequencer.sv
// Flag selector sequencer: auto-advances the flag every DWELL_FRAMES frames,
// accepts next/prev/load requests, and applies every change on a frame boundary.
module flag_sequencer #(
  parameter int NUM_FLAGS      = 59,
  parameter int SEL_W          = 8,
  parameter int COLOR_W        = 6,
  parameter int DWELL_FRAMES   = 120,
  parameter int HOLDOFF_FRAMES = 300,
  parameter int CNT_W          = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               display_on,
  input  logic               auto_en,
  input  logic               next_req,
  input  logic               prev_req,
  input  logic               load_req,
  input  logic [SEL_W-1:0]   load_val,
  input  logic [COLOR_W-1:0] flag_color_in,
  output logic [SEL_W-1:0]   sel,
  output logic [COLOR_W-1:0] color_out,
  output logic               changed,
  output logic [SEL_W-1:0]   count
);

  typedef enum logic {AUTO, MANUAL} state_t;

  localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_FLAGS - 1);
  localparam logic [SEL_W:0]   NUM_EXT    = (SEL_W+1)'(NUM_FLAGS);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_FRAMES - 1);

  state_t           state, state_nx;
  logic [SEL_W-1:0] sel_nx, load_latch, sel_succ, sel_pred;
  logic [CNT_W-1:0] dwell_cnt, dwell_nx, hold_cnt, hold_nx;
  logic             next_q, prev_q, load_q;
  logic             pend_next, pend_prev, pend_load;
  logic             rise_next, rise_prev, rise_load;
  logic             manual_act;

  assign count     = SEL_W'(NUM_FLAGS);
  assign rise_next = next_req & ~next_q;
  assign rise_prev = prev_req & ~prev_q;
  assign rise_load = load_req & ~load_q;
  assign sel_succ  = (sel == LAST_SEL) ? '0 : sel + 1'b1;
  assign sel_pred  = (sel == '0) ? LAST_SEL : sel - 1'b1;

  always_comb begin
    state_nx   = state;
    sel_nx     = sel;
    dwell_nx   = dwell_cnt;
    hold_nx    = hold_cnt;
    manual_act = 1'b0;
    if (frame_start) begin
      if (pend_load) begin
        sel_nx     = ({1'b0, load_latch} < NUM_EXT) ? load_latch : '0;
        manual_act = 1'b1;
      end else if (pend_next && !pend_prev) begin
        sel_nx     = sel_succ;
        manual_act = 1'b1;
      end else if (pend_prev && !pend_next) begin
        sel_nx     = sel_pred;
        manual_act = 1'b1;
      end
    end
    if (manual_act) begin
      state_nx = MANUAL;
      hold_nx  = '0;
      dwell_nx = '0;
    end else begin
      case (state)
        AUTO: begin
          if (!auto_en) begin
            dwell_nx = '0;
          end else if (frame_start) begin
            if (dwell_cnt == DWELL_LAST) begin
              sel_nx   = sel_succ;
              dwell_nx = '0;
            end else begin
              dwell_nx = dwell_cnt + 1'b1;
            end
          end
        end
        MANUAL: begin
          // Holdoff runs whether or not auto_en is set
          if (frame_start) begin
            if (hold_cnt == HOLD_LAST) begin
              state_nx = AUTO;
              dwell_nx = '0;
            end else begin
              hold_nx = hold_cnt + 1'b1;
            end
          end
        end
        default: state_nx = AUTO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= AUTO;
      sel        <= '0;
      dwell_cnt  <= '0;
      hold_cnt   <= '0;
      changed    <= 1'b0;
      color_out  <= '0;
      next_q     <= 1'b0;
      prev_q     <= 1'b0;
      load_q     <= 1'b0;
      pend_next  <= 1'b0;
      pend_prev  <= 1'b0;
      pend_load  <= 1'b0;
      load_latch <= '0;
    end else begin
      state     <= state_nx;
      sel       <= sel_nx;
      dwell_cnt <= dwell_nx;
      hold_cnt  <= hold_nx;
      changed   <= (sel_nx != sel);
      color_out <= display_on ? flag_color_in : '0;
      next_q    <= next_req;
      prev_q    <= prev_req;
      load_q    <= load_req;
      // Pending flags are consumed on frame_start; an edge in that same cycle waits a frame
      if (frame_start) begin
        pend_next <= rise_next;
        pend_prev <= rise_prev;
        pend_load <= rise_load;
      end else begin
        pend_next <= pend_next | rise_next;
        pend_prev <= pend_prev | rise_prev;
        pend_load <= pend_load | rise_load;
      end
      if (rise_load) load_latch <= load_val;
    end
  end

endmodule

// File: tb/tb_flag_sequencer.sv
// Bench for flag_sequencer: directed frame/request sequences, an integer
// reference model checked every cycle, and hand-computed literal checkpoints.
module tb_flag_sequencer;
  localparam int NF = 59, SW = 8, CW = 6, DW = 120, HO = 300, CNTW = 9;

  logic clk = 0, rst_n = 0, frame_start = 0, display_on = 0, auto_en = 0;
  logic next_req = 0, prev_req = 0, load_req = 0;
  logic [SW-1:0] load_val = '0;
  logic [CW-1:0] flag_color_in = 6'h15;
  logic [SW-1:0] sel, count;
  logic [CW-1:0] color_out;
  logic          changed;

  flag_sequencer #(.NUM_FLAGS(NF), .SEL_W(SW), .COLOR_W(CW), .DWELL_FRAMES(DW),
                   .HOLDOFF_FRAMES(HO), .CNT_W(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .display_on(display_on),
    .auto_en(auto_en), .next_req(next_req), .prev_req(prev_req), .load_req(load_req),
    .load_val(load_val), .flag_color_in(flag_color_in), .sel(sel),
    .color_out(color_out), .changed(changed), .count(count));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, chg_cnt = 0;

  // Reference model: integers, modular arithmetic, "frames since last manual action"
  int m_sel, m_dwell, m_hold, m_ll, m_color;
  bit m_manual, m_pn, m_pp, m_pl, m_nq, m_pq, m_lq, m_chg;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_dwell = 0; m_hold = 0; m_ll = 0; m_color = 0;
    m_manual = 0; m_pn = 0; m_pp = 0; m_pl = 0;
    m_nq = 0; m_pq = 0; m_lq = 0; m_chg = 0;
  endtask

  task automatic model_step();
    bit rn, rp, rl, act;
    int old;
    rn = next_req && !m_nq;
    rp = prev_req && !m_pq;
    rl = load_req && !m_lq;
    old = m_sel;
    act = 0;
    if (frame_start) begin
      if (m_pl) begin
        m_sel = (m_ll < NF) ? m_ll : 0; act = 1;
      end else if (m_pn && !m_pp) begin
        m_sel = (m_sel + 1) % NF; act = 1;
      end else if (m_pp && !m_pn) begin
        m_sel = (m_sel + NF - 1) % NF; act = 1;
      end
      if (act) begin
        m_manual = 1; m_hold = 0; m_dwell = 0;
      end else if (m_manual) begin
        if (m_hold == HO - 1) begin m_manual = 0; m_dwell = 0; end
        else m_hold++;
      end else if (auto_en) begin
        if (m_dwell == DW - 1) begin m_sel = (m_sel + 1) % NF; m_dwell = 0; end
        else m_dwell++;
      end else m_dwell = 0;
      m_pn = rn; m_pp = rp; m_pl = rl;
    end else begin
      m_pn |= rn; m_pp |= rp; m_pl |= rl;
      if (!m_manual && !auto_en) m_dwell = 0;
    end
    if (rl) m_ll = int'(load_val);
    m_nq = next_req; m_pq = prev_req; m_lq = load_req;
    m_chg = (m_sel != old);
    m_color = display_on ? int'(flag_color_in) : 0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check("sel", int'(sel), m_sel);
    check("changed", int'(changed), int'(m_chg));
    check("color_out", int'(color_out), m_color);
    check("count", int'(count), NF);
    if (changed) chg_cnt++;
  end

  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk) frame_start = 1;
      @(negedge clk) frame_start = 0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic req_edge(input bit n, input bit p, input bit l);
    @(negedge clk);
    next_req = n; prev_req = p; load_req = l;
    repeat (2) @(negedge clk);
    next_req = 0; prev_req = 0; load_req = 0;
    @(negedge clk);
  endtask

  initial begin
    int c0;
    logic [7:0] pat;
    repeat (2) @(negedge clk);
    check("reset_sel", int'(sel), 0);
    check("reset_color", int'(color_out), 0);
    check("reset_changed", int'(changed), 0);
    rst_n = 1;
    auto_en = 1;

    // Auto dwell: first advance on the 120th frame, full wrap after 59 periods
    c0 = chg_cnt;
    frames(119);
    check("dwell_119", int'(sel), 0);
    frames(1);
    check("dwell_120", int'(sel), 1);
    check("dwell_chg_pulses", chg_cnt - c0, 1);
    frames(57 * DW);
    check("dwell_58", int'(sel), 58);
    frames(DW);
    check("dwell_wrap", int'(sel), 0);

    // prev from 0 wraps to 58, then holdoff suspends auto-advance
    req_edge(0, 1, 0);
    frames(1);
    check("prev_wrap", int'(sel), 58);
    frames(HO - 1);
    check("holdoff_299", int'(sel), 58);
    frames(1);
    check("holdoff_300", int'(sel), 58);
    frames(DW - 1);
    check("post_hold_119", int'(sel), 58);
    frames(1);
    check("post_hold_120", int'(sel), 0);

    // next + prev in one frame cancel
    req_edge(1, 1, 0);
    c0 = chg_cnt;
    frames(1);
    check("cancel_sel", int'(sel), 0);
    check("cancel_no_chg", chg_cnt - c0, 0);

    // Loads: out-of-range goes to 0; load beats a simultaneous next
    auto_en = 0;
    req_edge(1, 0, 0);
    frames(1);
    check("next_to_1", int'(sel), 1);
    load_val = 8'd70;
    req_edge(0, 0, 1);
    frames(1);
    check("load_70", int'(sel), 0);
    load_val = 8'd42;
    req_edge(1, 0, 1);
    frames(1);
    check("load_42", int'(sel), 42);

    // Edge coincident with frame_start waits for the following frame
    @(negedge clk) begin frame_start = 1; next_req = 1; end
    @(negedge clk) begin frame_start = 0; next_req = 0; end
    repeat (2) @(negedge clk);
    check("coincident_hold", int'(sel), 42);
    frames(1);
    check("coincident_apply", int'(sel), 43);

    // Pixel path: one-cycle latency with blanking
    flag_color_in = 6'h3F;
    pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      display_on = pat[i];
      @(negedge clk);
      check("pix", int'(color_out), pat[i] ? 63 : 0);
    end

    // Reset mid-line drops a pending request
    display_on = 1;
    @(negedge clk) next_req = 1;
    @(negedge clk);
    rst_n = 0;
    #1;
    check("async_rst_sel", int'(sel), 0);
    check("async_rst_color", int'(color_out), 0);
    next_req = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    frames(1);
    check("rst_pend_lost", int'(sel), 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/flag_sequencer.md
Name: flag_sequencer

Overview:
- Sequential successor to the combinational flag colour mux. Owns the flag selector register and steps it automatically every DWELL_FRAMES frames, or manually on next/prev/load requests.
- Selector changes land only on frame boundaries, so a frame never mixes two flags.
- Sits between the VGA timing generator / input pins and the flag colour mux. Drives sel to the mux and registers the mux's returned colour into a 1-cycle pixel pipeline with blanking.

Parameters:
- NUM_FLAGS, 59: number of flags; selector range 0..NUM_FLAGS-1.
- SEL_W, 8: selector width; must satisfy 2**SEL_W >= NUM_FLAGS.
- COLOR_W, 6: colour width (RRGGBB).
- DWELL_FRAMES, 120: frames per flag in auto mode; must be >= 1.
- HOLDOFF_FRAMES, 300: frames auto-advance stays suspended after a manual action; must be >= 1.
- CNT_W, 9: dwell/holdoff counter width; must hold max(DWELL_FRAMES, HOLDOFF_FRAMES).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at the first cycle of vertical blanking
- display_on  in  1  high in the visible region
- auto_en  in  1  level; enables auto-advance
- next_req  in  1  level, already synchronised; a rising edge requests the next flag
- prev_req  in  1  level, already synchronised; a rising edge requests the previous flag
- load_req  in  1  level, already synchronised; a rising edge requests a jump to load_val
- load_val  in  SEL_W  jump target, sampled on the load_req rising edge
- flag_color_in  in  COLOR_W  combinational colour from the flag mux for the current sel
- sel  out  SEL_W  current flag index
- color_out  out  COLOR_W  registered pixel colour
- changed  out  1  one-cycle pulse on the cycle after sel updates
- count  out  SEL_W  constant NUM_FLAGS

Behaviour:
- Reset (async assert, sync release):
  - sel=0, color_out=0, changed=0.
  - state=AUTO; dwell_cnt=0, hold_cnt=0.
  - Edge-detect history registers=0; pend_next, pend_prev, pend_load=0; load_latch=0.
- Edge detection: a rising edge is req high while the registered previous value is low. A held level produces one request.
- Pending capture:
  - An edge sets its pending flag; pend_load also latches load_val.
  - Pending flags clear only on frame_start.
  - An edge in the same cycle as frame_start is captured and applied at the following frame_start.
- Manual actions, decided on frame_start only, in priority order:
  - pend_load: sel = load_latch if load_latch < NUM_FLAGS, else 0.
  - Else pend_next and pend_prev both set: they cancel; sel unchanged; not a manual action (no MANUAL transition).
  - Else pend_next: sel = (sel==NUM_FLAGS-1) ? 0 : sel+1.
  - Else pend_prev: sel = (sel==0) ? NUM_FLAGS-1 : sel-1.
  - Any applied action (load, next or prev) forces state=MANUAL, hold_cnt=0, dwell_cnt=0, and clears all pending flags.
- FSM, evaluated on frame_start only when no manual action applies:
  - AUTO, auto_en=1: if dwell_cnt==DWELL_FRAMES-1, advance as for next and set dwell_cnt=0; else dwell_cnt+1.
  - AUTO, auto_en=0: dwell_cnt forced to 0 on every cycle; sel holds.
  - MANUAL: if hold_cnt==HOLDOFF_FRAMES-1, state=AUTO and dwell_cnt=0; else hold_cnt+1. hold_cnt counts regardless of auto_en.
- changed: asserted exactly one cycle after any cycle in which sel's value changed. A load to the current value does not pulse.
- Pixel path, latency 1: color_out <= display_on ? flag_color_in : 0. The sel update takes effect on the pixel path starting the cycle after frame_start, which is inside blanking.
- count is combinational constant NUM_FLAGS.
- Reset mid-frame returns everything to the reset values immediately; in-flight pending requests are lost.

Test Plan:
- Defaults, auto_en=1, 120 frame_start pulses → sel goes 0→1 on the 120th pulse; changed pulses once; 59 dwell periods total → sel wraps 58→0.
- sel=0, prev_req rising edge, then frame_start → sel=58, state MANUAL. Then 299 frame_starts → sel still 58; on the 300th, state returns to AUTO with no advance; 120 further frame_starts → sel=0.
- next_req and prev_req edges in the same frame, then frame_start → sel unchanged, no changed pulse, state stays AUTO.
- load_req with load_val=70 → after frame_start, sel=0. load_val=42 issued together with next_req → sel=42.
- next_req edge in the same cycle as frame_start → sel unchanged at that pulse; sel increments at the next frame_start.
- display_on toggling with flag_color_in=6'h3F → color_out=6'h3F exactly one cycle after each display_on-high cycle, and 0 otherwise. rst_n low mid-line → color_out=0 and sel=0 asynchronously.
